mesh_row_readout: RTL and testbench
===================================

Name: mesh_row_readout

Overview:
Read-side companion to the 26x18 two-bit mesh. On a start pulse it waits a programmable settle time after new mesh inputs are applied. It then snapshots the 468-bit mesh result vector into a shadow register. It streams the snapshot out one 18-bit row per valid/ready handshake, row 0 first, so results can be drained off-chip or checked without a 468-bit wide interface.

Parameters:
ROWS, 26, number of mesh rows
COLS, 18, cells per row; also the output word width
SETTLE, 4, clock cycles to wait between accepted start and snapshot (0 allowed)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to capture and stream a result frame
mesh_out  in  ROWS*COLS (468)  mesh result vector; cell (r,c) at bit r*COLS+c
row_data  out  COLS (18)  current row = snapshot[r*COLS +: COLS]
row_idx  out  5  index r of row_data, 0..ROWS-1
row_valid  out  1  row_data/row_idx/last valid
row_ready  in  1  downstream accepts the row when row_valid & row_ready at the rising edge
last  out  1  high with row_valid while row_idx == ROWS-1
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the final row is accepted

Behaviour:
- Reset (async assert, sync release): state IDLE. row_data=0, row_idx=0, row_valid=0, last=0, busy=0, done=0, settle counter=0, shadow register=0.
- States: IDLE, WAIT, SEND.
- IDLE: done deasserts. When start=1 at an edge: go to WAIT, counter=SETTLE, busy=1.
- WAIT: at each edge, if counter==0 then shadow<=mesh_out, row_idx<=0, row_valid<=1, go to SEND. Otherwise decrement the counter.
- Capture latency: with start sampled at edge E0, the snapshot is taken at edge E0+SETTLE+1. row_valid is high immediately after that edge. With the default SETTLE, that is edge E0+5.
- SEND: row_data is always shadow row row_idx. Outputs hold stable while row_valid & !row_ready. row_valid never drops without a handshake.
- SEND, handshake with row_idx<ROWS-1: row_idx increments and row_valid stays high, giving back-to-back rows at full rate.
- SEND, handshake with row_idx==ROWS-1: row_valid<=0, row_idx<=0, go to IDLE, done<=1 for exactly one cycle, busy<=0.
- start while busy (WAIT or SEND) is ignored; it is not queued.
- start in the same cycle done is high is accepted normally, because the state is already IDLE.
- mesh_out changes after the snapshot do not affect streamed data.
- Reset mid-operation: all state and outputs return to reset values immediately, and the partial frame is discarded.
- row_idx width is 5 bits (covers 0..25). Values 26..31 are never produced.

Decomposition:
- Shared package mesh_pkg:
  - MESH_ROWS=26, MESH_COLS=18, CELL_IN_BITS=2
  - derived MESH_IN_W=936, MESH_OUT_W=468, ROW_IDX_W=5
  - state enum {IDLE, WAIT, SEND}
- One natural sub-module: mesh_row_select, a combinational shadow-to-row mux indexed by row_idx. It is reusable by a future input-side row loader.
- The FSM, settle counter and shadow register stay in the top module.

Test Plan:
1. Reset values: assert rst_n=0 mid-clock -> all outputs 0 immediately, with no clock edge needed.
2. Full frame, row_ready=1 constantly, mesh_out=ramp (row r = r+1), start at E0 -> snapshot at E5. Then 26 consecutive beats with row_data=1..26 and row_idx=0..25. last only on beat 25. done pulses at the edge after beat 25, and busy falls at the same time.
3. Backpressure: row_ready toggles 1,0,0,1,... with random stalls -> row_data and row_idx stable during stalls. No row is lost or duplicated; all 26 rows match the snapshot.
4. Snapshot isolation: capture mesh_out=all-ones, then drive mesh_out=0 during SEND -> all 26 rows read 18'h3FFFF.
5. start pulsed during WAIT and during SEND -> ignored; exactly one done. A start in the done cycle launches a second frame, captured SETTLE+1 edges later.
6. Reset at row 10 of SEND -> row_valid=0 and busy=0 immediately. A following start produces a complete fresh frame from row 0. Repeat with SETTLE=0: capture occurs on the edge after start is sampled.

Source files
------------

// File: rtl/mesh_pkg.sv
// Shared definitions for the 26x18 two-bit mesh and its readout path.
package mesh_pkg;

    localparam int MESH_ROWS    = 26;
    localparam int MESH_COLS    = 18;
    localparam int CELL_IN_BITS = 2;

    localparam int MESH_IN_W  = MESH_ROWS * MESH_COLS * CELL_IN_BITS;
    localparam int MESH_OUT_W = MESH_ROWS * MESH_COLS;
    localparam int ROW_IDX_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_t;

endpackage

// File: rtl/mesh_row_select.sv
// Combinational row mux: picks row i_idx out of a flat ROWS*COLS vector.
// Out-of-range indices yield zero. Built as a one-hot AND-OR so that no
// variable part-select is needed.
module mesh_row_select #(
    parameter int ROWS  = 26,
    parameter int COLS  = 18,
    parameter int IDX_W = 5
) (
    input  logic [ROWS*COLS-1:0] i_vec,
    input  logic [IDX_W-1:0]     i_idx,
    output logic [COLS-1:0]      o_row
);

    // One-hot select of the addressed row.
    always_comb begin
        o_row = {COLS{1'b0}};
        for (int r = 0; r < ROWS; r++) begin
            o_row = o_row | (i_vec[r*COLS +: COLS] & {COLS{i_idx == IDX_W'(r)}});
        end
    end

endmodule

// File: rtl/mesh_row_readout.sv
// Readout for the mesh result vector: after a start pulse, wait SETTLE
// cycles, snapshot the full result into a shadow register, then stream it
// out one row per valid/ready handshake, row 0 first.
module mesh_row_readout
    import mesh_pkg::*;
#(
    parameter int ROWS   = MESH_ROWS,
    parameter int COLS   = MESH_COLS,
    parameter int SETTLE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ROWS*COLS-1:0] mesh_out,
    output logic [COLS-1:0]      row_data,
    output logic [ROW_IDX_W-1:0] row_idx,
    output logic                 row_valid,
    input  logic                 row_ready,
    output logic                 last,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0]     SETTLE_INIT = CNT_W'(SETTLE);
    localparam logic [ROW_IDX_W-1:0] LAST_IDX    = ROW_IDX_W'(ROWS - 1);
    localparam logic [ROW_IDX_W-1:0] PENULT_IDX  = ROW_IDX_W'(ROWS - 2);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [ROWS*COLS-1:0]   r_shadow;
    logic [ROW_IDX_W-1:0]   r_idx;
    logic                   r_valid;
    logic                   r_last;
    logic                   r_busy;
    logic                   r_done;
    logic                   w_hs;
    logic                   w_at_last;
    logic                   w_cnt_zero;

    assign w_hs       = r_valid & row_ready;
    assign w_at_last  = (r_idx == LAST_IDX);
    assign w_cnt_zero = (r_cnt == {CNT_W{1'b0}});

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start outside IDLE is simply not looked at.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = WAIT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (w_cnt_zero) begin
                    w_state_nxt = SEND;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            SEND: begin
                if (w_hs && w_at_last) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = SEND;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: settle counter, snapshot, row index and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_shadow <= {(ROWS*COLS){1'b0}};
            r_idx    <= {ROW_IDX_W{1'b0}};
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_cnt  <= SETTLE_INIT;
                        r_busy <= 1'b1;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                WAIT: begin
                    if (w_cnt_zero) begin
                        r_shadow <= mesh_out;
                        r_idx    <= {ROW_IDX_W{1'b0}};
                        r_valid  <= 1'b1;
                        r_last   <= (LAST_IDX == {ROW_IDX_W{1'b0}});
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                SEND: begin
                    if (w_hs && w_at_last) begin
                        r_valid <= 1'b0;
                        r_idx   <= {ROW_IDX_W{1'b0}};
                        r_last  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_hs) begin
                        r_idx  <= r_idx + ROW_IDX_W'(1);
                        r_last <= (r_idx == PENULT_IDX);
                    end else begin
                        r_idx <= r_idx;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_idx   <= {ROW_IDX_W{1'b0}};
                    r_last  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    mesh_row_select #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .IDX_W (ROW_IDX_W)
    ) u_row_select (
        .i_vec (r_shadow),
        .i_idx (r_idx),
        .o_row (row_data)
    );

    assign row_idx   = r_idx;
    assign row_valid = r_valid;
    assign last      = r_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_mesh_row_readout.sv
// Bench for mesh_row_readout: one instance with SETTLE=4, one with SETTLE=0,
// a frame-level reference model, and directed scenarios with literal checks.
module tb_mesh_row_readout;

    localparam int R = 26;
    localparam int C = 18;

    logic           clk;
    logic           rst_n;
    logic           start_a;
    logic           start_b;
    logic [R*C-1:0] mesh_out;
    logic           row_ready;

    logic [C-1:0] rd_a, rd_b;
    logic [4:0]   ri_a, ri_b;
    logic         rv_a, rv_b, lst_a, lst_b, bsy_a, bsy_b, dn_a, dn_b;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    mesh_row_readout #(.ROWS(R), .COLS(C), .SETTLE(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .mesh_out(mesh_out),
        .row_data(rd_a), .row_idx(ri_a), .row_valid(rv_a), .row_ready(row_ready),
        .last(lst_a), .busy(bsy_a), .done(dn_a)
    );

    mesh_row_readout #(.ROWS(R), .COLS(C), .SETTLE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mesh_out(mesh_out),
        .row_data(rd_b), .row_idx(ri_b), .row_valid(rv_b), .row_ready(row_ready),
        .last(lst_b), .busy(bsy_b), .done(dn_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic hchk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    // A frame is: accepted start at cycle c, a snapshot of mesh_out at cycle
    // c+settle+1, then ROWS rows leave one per accepted handshake.
    logic [R*C-1:0] m_snap [2];
    int             m_left [2];
    bit             m_pend [2];
    int             m_cap_at [2];
    bit             m_done [2];
    int             m_settle [2];
    int             cyc = 0;

    initial begin
        m_settle[0] = 4;
        m_settle[1] = 0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_snap[k]   = '0;
                m_left[k]   = 0;
                m_pend[k]   = 1'b0;
                m_cap_at[k] = 0;
                m_done[k]   = 1'b0;
            end
        end else begin
            cyc++;
            for (int k = 0; k < 2; k++) begin
                logic st;
                st = (k == 0) ? start_a : start_b;
                m_done[k] = 1'b0;
                if (m_left[k] > 0) begin
                    if (row_ready) begin
                        m_left[k]--;
                        if (m_left[k] == 0) m_done[k] = 1'b1;
                    end
                end else if (m_pend[k]) begin
                    if (cyc == m_cap_at[k]) begin
                        m_snap[k] = mesh_out;
                        m_left[k] = R;
                        m_pend[k] = 1'b0;
                    end
                end else if (st) begin
                    m_pend[k]   = 1'b1;
                    m_cap_at[k] = cyc + m_settle[k] + 1;
                end
            end
        end
    end

    task automatic cmp(input int k, input logic [C-1:0] d, input logic [4:0] i,
                       input logic v, input logic l, input logic b, input logic dn);
        int ei;
        logic [C-1:0] ed;
        ei = (m_left[k] > 0) ? (R - m_left[k]) : 0;
        ed = m_snap[k][ei*C +: C];
        hchk($sformatf("model_valid_%0d", k), v, (m_left[k] > 0));
        hchk($sformatf("model_idx_%0d", k), i, ei);
        hchk($sformatf("model_data_%0d", k), d, ed);
        hchk($sformatf("model_last_%0d", k), l, (m_left[k] == 1));
        hchk($sformatf("model_busy_%0d", k), b, (m_pend[k] || m_left[k] > 0));
        hchk($sformatf("model_done_%0d", k), dn, m_done[k]);
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, rd_a, ri_a, rv_a, lst_a, bsy_a, dn_a);
            cmp(1, rd_b, ri_b, rv_b, lst_b, bsy_b, dn_b);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [R*C-1:0] ramp(input int mul, input int add);
        logic [R*C-1:0] v;
        v = '0;
        for (int r = 0; r < R; r++) v[r*C +: C] = C'(r * mul + add);
        return v;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_valid_a(input int maxc);
        int n = 0;
        while (!rv_a && n < maxc) begin step(); n++; end
        hchk("wait_valid_a", rv_a, 1);
    endtask

    task automatic wait_done_a(input int maxc);
        int n = 0;
        while (!dn_a && n < maxc) begin step(); n++; end
        hchk("wait_done_a", dn_a, 1);
    endtask

    task automatic pulse_a();
        start_a = 1'b1; step(); start_a = 1'b0;
    endtask

    initial begin
        logic [R*C-1:0] ref_v;
        int exp_idx;
        int n;
        bit pat [8];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        mesh_out = '0; row_ready = 1'b1;
        step(); step();
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Reset values
        hchk("rst_valid", rv_a, 0);
        hchk("rst_data", rd_a, 0);
        hchk("rst_idx", ri_a, 0);
        hchk("rst_busy", bsy_a, 0);
        hchk("rst_done", dn_a, 0);
        hchk("rst_last", lst_a, 0);

        // Full frame at full rate, row r = r+1
        mesh_out = ramp(1, 1);
        pulse_a();                      // now just after E0
        hchk("f_busy", bsy_a, 1);
        repeat (4) step();              // after E4
        hchk("f_valid_e4", rv_a, 0);
        step();                         // after E5
        hchk("f_valid_e5", rv_a, 1);
        for (int b = 0; b < R; b++) begin
            hchk("f_idx", ri_a, b);
            hchk("f_data", rd_a, b + 1);
            hchk("f_last", lst_a, (b == R - 1));
            hchk("f_done_low", dn_a, 0);
            step();
        end
        hchk("f_done", dn_a, 1);
        hchk("f_busy_fall", bsy_a, 0);
        hchk("f_valid_fall", rv_a, 0);
        step();
        hchk("f_done_once", dn_a, 0);

        // Backpressure with patterned and random stalls
        mesh_out = ramp(3, 7);
        ref_v = ramp(3, 7);
        pulse_a();
        exp_idx = 0;
        n = 0;
        while (!dn_a && n < 400) begin
            row_ready = pat[n % 8] ^ ($urandom_range(0, 3) == 0);
            if (rv_a && row_ready) begin
                hchk("bp_idx", ri_a, exp_idx);
                hchk("bp_data", rd_a, ref_v[exp_idx*C +: C]);
                exp_idx++;
            end
            step();
            n++;
        end
        hchk("bp_done", dn_a, 1);
        hchk("bp_rows", exp_idx, R);
        row_ready = 1'b1;
        step();

        // Snapshot isolation
        mesh_out = '1;
        pulse_a();
        wait_valid_a(10);
        mesh_out = '0;
        exp_idx = 0;
        n = 0;
        while (!dn_a && n < 40) begin
            if (rv_a) begin
                hchk("iso_data", rd_a, 18'h3FFFF);
                exp_idx++;
            end
            step();
            n++;
        end
        hchk("iso_rows", exp_idx, R);
        step();

        // start ignored while busy; start in the done cycle is accepted
        mesh_out = ramp(1, 100);
        pulse_a();
        step();
        pulse_a();                      // during WAIT
        wait_valid_a(10);
        step(); step();
        pulse_a();                      // during SEND
        n = 0;
        while (!dn_a && n < 60) begin
            n++;
            hchk("ign_no_early_done", dn_a, 0);
            step();
        end
        hchk("ign_done", dn_a, 1);
        mesh_out = ramp(2, 1);
        pulse_a();                      // start sampled in the done cycle
        hchk("back2back_busy", bsy_a, 1);
        repeat (4) step();
        hchk("b2b_valid_e4", rv_a, 0);
        step();
        hchk("b2b_valid_e5", rv_a, 1);
        hchk("b2b_data0", rd_a, 1);
        wait_done_a(40);
        step();

        // Reset in the middle of SEND
        mesh_out = ramp(1, 1);
        pulse_a();
        wait_valid_a(10);
        n = 0;
        while (ri_a != 5'd10 && n < 40) begin step(); n++; end
        hchk("mid_idx10", ri_a, 10);
        #2 rst_n = 1'b0;
        #1;
        hchk("mid_rst_valid", rv_a, 0);
        hchk("mid_rst_busy", bsy_a, 0);
        hchk("mid_rst_idx", ri_a, 0);
        hchk("mid_rst_data", rd_a, 0);
        step();
        rst_n = 1'b1;
        mesh_out = ramp(2, 5);
        pulse_a();
        wait_valid_a(10);
        hchk("fresh_idx0", ri_a, 0);
        hchk("fresh_data0", rd_a, 5);
        wait_done_a(40);
        step();

        // SETTLE=0 instance: capture on the edge after start is sampled
        mesh_out = ramp(1, 9);
        start_b = 1'b1; step(); start_b = 1'b0;
        hchk("s0_valid_e0", rv_b, 0);
        hchk("s0_busy", bsy_b, 1);
        step();
        hchk("s0_valid_e1", rv_b, 1);
        hchk("s0_data0", rd_b, 9);
        n = 0;
        while (!dn_b && n < 40) begin step(); n++; end
        hchk("s0_done", dn_b, 1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
